// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the behavioural main-memory responder.
// Contents:
//   LINE_W / WORD_W : line width (512) and word width (32) used for fills
//   ADDR_W          : line address width ({tag, index} = 26 bits)
//   state_t         : responder FSM states
//   fill_line()     : deterministic, address-derived refill pattern
package mem_pkg;

    localparam int LINE_W = 512;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 26;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        WAIT_DROP
    } state_t;

    // Word k of a missing line is {line_addr, k[3:0], 2'b00}, so a bench can
    // check any refill from the address alone.
    function automatic logic [LINE_W-1:0] fill_line(input logic [ADDR_W-1:0] line_addr);
        logic [LINE_W-1:0] v;
        v = '0;
        for (int k = 0; k < LINE_W / WORD_W; k++) begin
            v[k*WORD_W +: WORD_W] = {line_addr, k[3:0], 2'b00};
        end
        return v;
    endfunction

endpackage

// File: rtl/mem_line_store.sv
// mem_line_store: direct-mapped residency store for mem_responder.
// Ports:
//   i_clk, i_nrst   : clock, synchronous active-low reset (clears valid bits)
//   i_lookupAddr    : line address for the combinational lookup
//   o_hit           : entry valid and its stored address matches
//   o_lookupData    : stored line of the looked-up slot
//   i_wrEn          : install i_wrAddr / i_wrData into its slot this cycle
//   i_wrAddr        : line address to install
//   i_wrData        : line data to install
module mem_line_store
    import mem_pkg::*;
#(
    parameter int LBITS = 6,
    parameter int AW    = ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic [AW-1:0]     i_lookupAddr,
    output logic              o_hit,
    output logic [LINE_W-1:0] o_lookupData,
    input  logic              i_wrEn,
    input  logic [AW-1:0]     i_wrAddr,
    input  logic [LINE_W-1:0] i_wrData
);

    localparam int DEPTH = 1 << LBITS;

    logic [DEPTH-1:0]  r_valid;
    logic [AW-1:0]     r_addr [DEPTH];
    logic [LINE_W-1:0] r_data [DEPTH];

    logic [LBITS-1:0]  w_lookupSlot;
    logic [LBITS-1:0]  w_wrSlot;

    assign w_lookupSlot = i_lookupAddr[LBITS-1:0];
    assign w_wrSlot     = i_wrAddr[LBITS-1:0];

    // The full line address is stored, so a slot holding a different line
    // that shares the low bits reads as a miss.
    assign o_hit        = r_valid[w_lookupSlot] && (r_addr[w_lookupSlot] == i_lookupAddr);
    assign o_lookupData = r_data[w_lookupSlot];

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_valid <= '0;
        end else if (i_wrEn) begin
            r_valid[w_wrSlot] <= 1'b1;
        end
    end

    // Address and data arrays are never cleared; validity alone decides hits.
    always_ff @(posedge i_clk) begin
        if (i_nrst && i_wrEn) begin
            r_addr[w_wrSlot] <= i_wrAddr;
            r_data[w_wrSlot] <= i_wrData;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: behavioural main memory on the memory side of L2<->MEM.
// Accepts one line read or write, waits a modelled latency, then pulses
// o_ready_MEM_L2 for one cycle. Reads return stored data on a hit or the
// address-derived fill pattern on a miss (which is then installed).
// Build option:
//   MEM_MISS_MODEL_EN defined   : hits take HIT_LAT, misses take MISS_LAT
//   MEM_MISS_MODEL_EN undefined : every access takes HIT_LAT
// Ports:
//   i_clk, i_nrst                          : clock, synchronous active-low reset
//   i_read_L2_MEM / i_write_L2_MEM         : level requests, held until ready
//   i_index_L2_MEM / i_tag_L2_MEM          : read line address
//   i_write_index_L2_MEM / i_write_tag_L2_MEM : write line address
//   i_write_data_L2_MEM                    : write line data
//   o_ready_MEM_L2                         : one-cycle completion pulse
//   o_read_data_MEM_L2                     : read data, held until next read completes
module mem_responder
    import mem_pkg::*;
#(
    parameter int TNUM     = 18,
    parameter int INUM     = 8,
    parameter int LBITS    = 6,
    parameter int HIT_LAT  = 2,
    parameter int MISS_LAT = 12
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_read_L2_MEM,
    input  logic              i_write_L2_MEM,
    input  logic [INUM-1:0]   i_index_L2_MEM,
    input  logic [TNUM-1:0]   i_tag_L2_MEM,
    input  logic [INUM-1:0]   i_write_index_L2_MEM,
    input  logic [TNUM-1:0]   i_write_tag_L2_MEM,
    input  logic [LINE_W-1:0] i_write_data_L2_MEM,
    output logic              o_ready_MEM_L2,
    output logic [LINE_W-1:0] o_read_data_MEM_L2
);

    localparam int AW = TNUM + INUM;
    localparam int CW = $clog2(MISS_LAT + 1);

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic              r_isWrite;
    logic              r_hit;
    logic [AW-1:0]     r_lineAddr;
    logic [LINE_W-1:0] r_wrData;
    logic              r_ready;
    logic [LINE_W-1:0] r_rdData;

    logic [AW-1:0]     w_reqAddr;
    logic [AW-1:0]     w_lookupAddr;
    logic              w_hit;
    logic [LINE_W-1:0] w_lookupData;
    logic [CW-1:0]     w_lat;
    logic              w_lastCount;
    logic              w_storeWe;
    logic [LINE_W-1:0] w_fillData;
    logic [LINE_W-1:0] w_storeData;
    logic              w_servedReq;

    // Writes take priority, so the request address follows the write line.
    assign w_reqAddr    = i_write_L2_MEM ? {i_write_tag_L2_MEM, i_write_index_L2_MEM}
                                         : {i_tag_L2_MEM, i_index_L2_MEM};
    // In IDLE the store is probed with the incoming request; afterwards with
    // the latched address so a read hit can pick up its data at completion.
    assign w_lookupAddr = (r_state == IDLE) ? w_reqAddr : r_lineAddr;

`ifdef MEM_MISS_MODEL_EN
    assign w_lat = w_hit ? CW'(HIT_LAT) : CW'(MISS_LAT);
`else
    assign w_lat = CW'(HIT_LAT);
`endif

    assign w_lastCount = (r_state == BUSY) && (r_count == CW'(1));
    assign w_fillData  = fill_line(r_lineAddr);
    // Writes allocate; read misses install the fill; read hits leave the store alone.
    assign w_storeWe   = w_lastCount && (r_isWrite || !r_hit);
    assign w_storeData = r_isWrite ? r_wrData : w_fillData;
    assign w_servedReq = r_isWrite ? i_write_L2_MEM : i_read_L2_MEM;

    mem_line_store #(
        .LBITS (LBITS),
        .AW    (AW)
    ) u_store (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_lookupAddr (w_lookupAddr),
        .o_hit        (w_hit),
        .o_lookupData (w_lookupData),
        .i_wrEn       (w_storeWe),
        .i_wrAddr     (r_lineAddr),
        .i_wrData     (w_storeData)
    );

    // Counter is loaded with the full latency at accept and the access is
    // performed when it reaches its last count, so ready rises exactly LAT
    // edges after the accepting edge.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_isWrite  <= 1'b0;
            r_hit      <= 1'b0;
            r_lineAddr <= '0;
            r_wrData   <= '0;
            r_ready    <= 1'b0;
            r_rdData   <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_write_L2_MEM || i_read_L2_MEM) begin
                        r_isWrite  <= i_write_L2_MEM;
                        r_lineAddr <= w_reqAddr;
                        r_wrData   <= i_write_data_L2_MEM;
                        r_hit      <= w_hit;
                        r_count    <= w_lat;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_count <= r_count - CW'(1);
                    if (w_lastCount) begin
                        if (!r_isWrite) begin
                            r_rdData <= r_hit ? w_lookupData : w_fillData;
                        end
                        r_ready <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    // Only the served op's line matters; the other op may
                    // already be pending and is taken from IDLE.
                    if (!w_servedReq) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready_MEM_L2     = r_ready;
    assign o_read_data_MEM_L2 = r_rdData;

endmodule
